// File: rtl/lzd_normalizer.sv
// ---------------------------------------------------------------------------
// lzd_normalizer
//   Multi-cycle leading-zero detector / normaliser. The operand is scanned
//   CHUNK bits per cycle from the MSB. An all-zero chunk costs one cycle and
//   advances by CHUNK. The first nonzero chunk finishes the scan in that
//   same cycle, using a small priority encoder on the chunk.
//
//   States:
//     IDLE - waiting for an operand (in_ready=1)
//     SCAN - walking chunks from the MSB
//     DONE - result held until the consumer takes it (out_valid=1)
//
//   Parameters:
//     WIDTH   operand width (>= 2)
//     CHUNK   bits examined per scan cycle (WIDTH % CHUNK == 0)
//
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     in_data    operand
//     in_valid   operand valid
//     in_ready   block idle, accepts an operand
//     out_count  leading-zero count, 0..WIDTH
//     out_zero   operand was zero
//     out_norm   operand shifted left by out_count
//     out_valid  result valid
//     out_ready  consumer takes the result
//
//   Build option:
//     LZD_NORM_OUT_EN  defined: a shift register produces out_norm.
//                      undefined: out_norm is tied to 0. The operand is held
//                      unshifted and a chunk pointer selects the chunk being
//                      scanned. Count, zero flag and timing do not change.
// ---------------------------------------------------------------------------
module lzd_normalizer #(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            zero_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [CHUNK-1:0] top_chunk;
  logic             chunk_nz;
  logic [CW-1:0]    chunk_k;
  logic             last_chunk;
  logic [CW-1:0]    cnt_d;

  // Leading zeros within one chunk. Only used when the chunk is nonzero,
  // so the result is 0..CHUNK-1.
  function automatic logic [CW-1:0] chunk_lzc(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!found) begin
        if (c[i]) found = 1'b1;
        else      n     = n + CW'(1);
      end
    end
    return n;
  endfunction

`ifdef LZD_NORM_OUT_EN
  logic [WIDTH-1:0] sr_q;

  assign top_chunk  = sr_q[WIDTH-1 -: CHUNK];
  // cnt_q has advanced by CHUNK for each zero chunk seen so far.
  assign last_chunk = (cnt_q == CW'(WIDTH - CHUNK));
  assign out_norm   = sr_q;
`else
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic [WIDTH-1:0] op_q;
  logic [IW-1:0]    idx_q;

  always_comb begin
    top_chunk = '0;
    for (int j = 0; j < NCH; j++) begin
      if (idx_q == IW'(j)) top_chunk = op_q[WIDTH-1-j*CHUNK -: CHUNK];
    end
  end

  assign last_chunk = (idx_q == IW'(NCH - 1));
  assign out_norm   = '0;
`endif

  assign chunk_nz = |top_chunk;
  assign chunk_k  = chunk_lzc(top_chunk);
  assign cnt_d    = chunk_nz ? (cnt_q + chunk_k) : (cnt_q + CW'(CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef LZD_NORM_OUT_EN
      sr_q        <= '0;
`else
      op_q        <= '0;
      idx_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q      <= '0;
            zero_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
`ifdef LZD_NORM_OUT_EN
            sr_q       <= in_data;
`else
            op_q       <= in_data;
            idx_q      <= '0;
`endif
          end
        end

        SCAN: begin
          cnt_q <= cnt_d;
          if (chunk_nz) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef LZD_NORM_OUT_EN
            sr_q        <= sr_q << chunk_k;
`endif
          end else begin
`ifdef LZD_NORM_OUT_EN
            sr_q  <= sr_q << CHUNK;
`else
            idx_q <= idx_q + IW'(1);
`endif
            // The final zero chunk takes the count to WIDTH and leaves
            // the shift register at 0.
            if (last_chunk) begin
              zero_q      <= 1'b1;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzd_normalizer.sv
module tb_lzd_normalizer;

  logic clk;
  logic rst;

  // 16-bit / 4-bit-chunk instance
  logic [15:0] id16;
  logic        iv16, ir16, oz16, ov16, or16;
  logic [4:0]  oc16;
  logic [15:0] on16;

  // 8-bit / 1-bit-chunk instance
  logic [7:0]  id8;
  logic        iv8, ir8, oz8, ov8, or8;
  logic [3:0]  oc8;
  logic [7:0]  on8;

  lzd_normalizer #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_data(id16), .in_valid(iv16), .in_ready(ir16),
    .out_count(oc16), .out_zero(oz16), .out_norm(on16), .out_valid(ov16),
    .out_ready(or16)
  );

  lzd_normalizer #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .rst(rst), .in_data(id8), .in_valid(iv8), .in_ready(ir8),
    .out_count(oc8), .out_zero(oz8), .out_norm(on8), .out_valid(ov8),
    .out_ready(or8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] norm;
    int          cnt;
    bit          zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t cur16, cur8;
  bit   seen16 = 0, seen8 = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input int w, input int c, input int acc);
    exp_t e;
    e.cnt = w;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) begin
        e.cnt = w - 1 - i;
        break;
      end
    end
    e.zero = (e.cnt == w);
    e.lat  = e.zero ? (w / c) : (e.cnt / c + 1);
`ifdef LZD_NORM_OUT_EN
    e.norm = e.zero ? 16'h0 : ((d << e.cnt) & ((w == 16) ? 16'hFFFF : 16'h00FF));
`else
    e.norm = 16'h0;
`endif
    e.acc = acc;
    return e;
  endfunction

  // Output monitors: pop on the first cycle of out_valid, then require the
  // result to stay put for as long as it is held.
  always @(negedge clk) begin
    if (rst) begin
      seen16 = 0;
    end else if (ov16) begin
      if (!seen16) begin
        if (q16.size() == 0) begin
          chk("spurious16", 32'(ov16), 32'd0);
        end else begin
          cur16 = q16.pop_front();
          chk("cnt16",  32'(oc16), 32'(cur16.cnt));
          chk("zero16", 32'(oz16), 32'(cur16.zero));
          chk("norm16", 32'(on16), 32'(cur16.norm));
          chk("lat16",  32'(cyc - cur16.acc), 32'(cur16.lat));
        end
        seen16 = 1;
      end else begin
        chk("hold_cnt16",  32'(oc16), 32'(cur16.cnt));
        chk("hold_norm16", 32'(on16), 32'(cur16.norm));
        chk("hold_zero16", 32'(oz16), 32'(cur16.zero));
      end
    end else begin
      seen16 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      seen8 = 0;
    end else if (ov8) begin
      if (!seen8) begin
        if (q8.size() == 0) begin
          chk("spurious8", 32'(ov8), 32'd0);
        end else begin
          cur8 = q8.pop_front();
          chk("cnt8",  32'(oc8), 32'(cur8.cnt));
          chk("zero8", 32'(oz8), 32'(cur8.zero));
          chk("norm8", 32'(on8), 32'(cur8.norm));
          chk("lat8",  32'(cyc - cur8.acc), 32'(cur8.lat));
        end
        seen8 = 1;
      end
    end else begin
      seen8 = 0;
    end
  end

  // Drivers: called on a negedge; wait for in_ready, present the operand for
  // one cycle, and record the expectation with the accept-edge number.
  task automatic send16(input logic [15:0] d);
    int t = 0;
    while (!ir16 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir16) begin
      chk("send16_timeout", 32'd0, 32'd1);
      return;
    end
    q16.push_back(model(d, 16, 4, cyc + 1));
    id16 = d;
    iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    id16 = $urandom;
  endtask

  task automatic send8(input logic [7:0] d);
    int t = 0;
    while (!ir8 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir8) begin
      chk("send8_timeout", 32'd0, 32'd1);
      return;
    end
    q8.push_back(model({8'h00, d}, 8, 1, cyc + 1));
    id8 = d;
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  initial begin
    int   t;
    logic ov_seen;
    logic [15:0] pat [8] = '{16'h0010, 16'h8001, 16'h0000, 16'hFFFF,
                             16'h0001, 16'h0F00, 16'h00C3, 16'h2000};

    rst  = 1'b1;
    iv16 = 1'b0; id16 = '0; or16 = 1'b1;
    iv8  = 1'b0; id8  = '0; or8  = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready",  32'(ir16), 32'd1);
    chk("rst_out_valid", 32'(ov16), 32'd0);
    chk("rst_out_count", 32'(oc16), 32'd0);
    chk("rst_out_zero",  32'(oz16), 32'd0);
    chk("rst_out_norm",  32'(on16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (pat[i]) send16(pat[i]);
    for (int i = 0; i < 6; i++) send16(16'($urandom));

    // Back-pressure: hold the result of 0x0300 for five cycles.
    t = 0;
    while (!ir16 && t < 200) begin @(negedge clk); t++; end
    or16 = 1'b0;
    send16(16'h0300);
    t = 0;
    while (!ov16 && t < 50) begin @(negedge clk); t++; end
    chk("stall_valid_seen", 32'(ov16), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(ir16), 32'd0);
      chk("stall_valid",    32'(ov16), 32'd1);
      chk("stall_count",    32'(oc16), 32'd6);
      @(negedge clk);
    end
    or16 = 1'b1;
    chk("pre_release_in_ready", 32'(ir16), 32'd0);
    @(negedge clk);
    chk("post_release_in_ready", 32'(ir16), 32'd1);
    chk("post_release_valid",    32'(ov16), 32'd0);

    // Reset during the second scan cycle of 0x0001: no result may appear.
    id16 = 16'h0001;
    iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    chk("rst_mid_scan_busy", 32'(ir16), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(ir16), 32'd1);
    chk("rst_mid_valid",    32'(ov16), 32'd0);
    chk("rst_mid_count",    32'(oc16), 32'd0);
    chk("rst_mid_norm",     32'(on16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) ov_seen = 1'b1;
    end
    chk("rst_discarded", 32'(ov_seen), 32'd0);
    send16(16'h4000);

    // Exhaustive sweep on the 8-bit, 1-bit-chunk instance.
    for (int d = 0; d < 256; d++) send8(8'(d));

    t = 0;
    while ((q16.size() != 0 || q8.size() != 0 || ov16 || ov8) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain16", 32'(q16.size()), 32'd0);
    chk("drain8",  32'(q8.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lzd_normalizer.md
LZD_NORMALIZER -- requirements
Module: lzd_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; legal values >= 2.
REQ-002 SHALL have parameter CHUNK, default 4: bits scanned per cycle; legal values >= 1, and WIDTH SHALL be a multiple of CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_data, input, WIDTH bits: operand.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-008 SHALL have port out_count, output, CW = clog2(WIDTH+1) bits: number of leading zeros.
REQ-009 SHALL have port out_zero, output, 1 bit: operand was all zeros.
REQ-010 SHALL have port out_norm, output, WIDTH bits: operand shifted left by out_count.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Accept occurs when in_valid && in_ready at a clock edge: in_data is loaded into shift register SR, the count register is cleared, and the FSM goes to SCAN.
REQ-016 In SCAN, if the top CHUNK bits of SR are all 0: shift SR left by CHUNK, add CHUNK to count, and stay in SCAN.
REQ-017 In SCAN, if the top CHUNK bits of SR are nonzero: add the leading-zero count k (0..CHUNK-1) of that chunk to count, shift SR left by k, and go to DONE.
REQ-018 If WIDTH/CHUNK consecutive all-zero chunks are scanned, count SHALL equal WIDTH, out_zero SHALL be 1, out_norm SHALL be 0, and the FSM goes to DONE.
REQ-019 Latency: scan cycles SHALL equal 1 + the index of the first nonzero chunk from the MSB (WIDTH/CHUNK for a zero operand); out_valid SHALL rise on the edge that ends the final scan cycle.
REQ-020 In DONE, out_count, out_zero and out_norm SHALL stay stable while out_valid=1 && out_ready=0.
REQ-021 A DONE -> IDLE transition occurs on out_valid && out_ready; in_ready SHALL rise the following cycle, so there is no same-cycle accept on result handoff.
REQ-022 in_data and in_valid SHALL be ignored outside IDLE.
REQ-023 out_count SHALL range over 0..WIDTH without wrap; a count of WIDTH implies out_zero=1.
REQ-024 For out_zero=0, out_norm[WIDTH-1] SHALL be 1.
REQ-025 out_ready in a state other than DONE SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force IDLE asynchronously, in any state including mid-SCAN or in DONE with a pending result.
REQ-027 During and after reset: in_ready=1 from IDLE, out_valid=0, out_count=0, out_zero=0, out_norm=0, and SR and the count register cleared.
REQ-028 Any in-flight operand at reset SHALL be discarded, with no output produced for it.

Configuration
REQ-029 Macro LZD_NORM_OUT_EN SHALL control normalised-output support.
REQ-030 With LZD_NORM_OUT_EN defined: out_norm SHALL be driven per REQ-017, REQ-018 and REQ-024.
REQ-031 Without LZD_NORM_OUT_EN: out_norm SHALL be tied to 0, the data shift SHALL be replaced by a chunk index pointer over a held operand copy, and out_count, out_zero and timing SHALL be identical to the enabled build.

Verification
REQ-032 WIDTH=16, CHUNK=4, in_data=0x0010 -> 3 scan cycles; out_count=11, out_zero=0, out_norm=0x8000.
REQ-033 WIDTH=16, CHUNK=4, in_data=0x8001 -> 1 scan cycle; out_count=0, out_norm=0x8001.
REQ-034 in_data=0x0000 -> 4 scan cycles; out_count=16, out_zero=1, out_norm=0x0000.
REQ-035 in_data=0x0300 with out_ready held 0 for 5 cycles -> out_valid=1 and out_count=6 held stable, in_ready=0 throughout; in_ready=1 on the cycle after out_ready=1.
REQ-036 rst pulsed during the 2nd scan cycle of 0x0001 -> immediate IDLE, out_valid never asserts, and the next operand 0x4000 gives out_count=1.
REQ-037 WIDTH=8, CHUNK=1 with a sweep of all 256 operands -> out_count matches a reference leading-zero count and latency equals out_count+1 (8 cycles for 0x00), in both macro builds.
